// File: rtl/param_data_memory.sv
// param_data_memory: parametrised single-port data RAM with byte writes,
// request/response handshake, 1- or 2-cycle reads and a post-reset clear sweep.
module param_data_memory #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_acc;
  logic              w_inr;
  logic              w_wr;
  logic              w_rd;
  logic              w_clr;

  logic              r_v1;
  logic              r_e1;
  logic [DATA_W-1:0] r_d1;

  assign w_acc = req_valid & req_ready;
  assign w_inr = {1'b0, req_addr} < DEPTH_X;
  assign w_wr  = w_acc & req_we & w_inr;
  assign w_rd  = w_acc & ~req_we;
  assign w_clr = (r_state == S_CLEAR) & rst;

  // State register and clear pointer; reset restarts the sweep at 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR)
        r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  // Next state and handshake outputs; leave CLEAR once the last word is zeroed
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        busy = 1'b1;
        if (r_ptr == LAST)
          w_state_nxt = S_READY;
      end
      S_READY: begin
        req_ready = 1'b1;
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // Array writes: zero sweep while clearing, byte-masked stores when ready
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i])
          r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // First read stage; out-of-range reads return zero with the error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_rd;
      r_e1 <= w_rd & ~w_inr;
      r_d1 <= (w_rd & w_inr) ? r_mem[req_addr] : '0;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_v2;
      logic              r_e2;
      logic [DATA_W-1:0] r_d2;

      // Extra output register stage for the two-cycle read mode
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_v2 <= 1'b0;
          r_e2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          r_e2 <= r_e1;
          r_d2 <= r_d1;
        end
      end

      assign resp_valid = r_v2;
      assign resp_err   = r_e2;
      assign resp_rdata = r_d2;
    end else begin : g_lat1
      assign resp_valid = r_v1;
      assign resp_err   = r_e1;
      assign resp_rdata = r_d1;
    end
  endgenerate

endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: two DUT configurations driven in lockstep,
// scoreboard queues checked by a negedge monitor against an array model.
module tb_param_data_memory;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_be = '0;

  logic          rdy_a, bsy_a, rv_a, re_a;
  logic [DW-1:0] rd_a;
  logic          rdy_b, bsy_b, rv_b, re_b;
  logic [DW-1:0] rd_b;

  always #5 clk = ~clk;

  param_data_memory u_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy_a),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv_a), .resp_rdata(rd_a),
    .resp_err(re_a), .busy(bsy_a)
  );

  param_data_memory #(
    .DEPTH(1000), .READ_LAT(2)
  ) u_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rdy_b),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv_b), .resp_rdata(rd_b),
    .resp_err(re_b), .busy(bsy_b)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        e;
    int          due;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] mdl [2][1024];
  int          dep [2] = '{1024, 1000};
  int          lat [2] = '{1, 2};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic flush();
    qa.delete();
    qb.delete();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 1024; a++)
        mdl[k][a] = 16'h0000;
  endtask

  task automatic issue(input logic we, input int addr,
                       input logic [15:0] wd, input logic [1:0] be);
    exp_t x;
    @(posedge clk);
    #2;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = wd;
    req_be    = be;
    for (int k = 0; k < 2; k++) begin
      if (we) begin
        if (addr < dep[k])
          for (int b = 0; b < 2; b++)
            if (be[b]) mdl[k][addr][8*b +: 8] = wd[8*b +: 8];
      end else begin
        x.d   = (addr < dep[k]) ? mdl[k][addr] : 16'h0000;
        x.e   = (addr >= dep[k]);
        x.due = cyc + lat[k];
        if (k == 0) qa.push_back(x);
        else qb.push_back(x);
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    req_valid = 1'b0;
  endtask

  task automatic mon(input int k, input logic v,
                     input logic [15:0] d, input logic e);
    exp_t x;
    int n;
    n = (k == 0) ? qa.size() : qb.size();
    if (v) begin
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL spurious[%0d] cyc=%0d got data=%h err=%b, required no response",
                 k, cyc, d, e);
      end else begin
        if (k == 0) x = qa.pop_front();
        else x = qb.pop_front();
        if (d !== x.d || e !== x.e || cyc != x.due) begin
          errors++;
          $display("FAIL resp[%0d] got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                   k, d, e, cyc, x.d, x.e, x.due);
        end
      end
    end else begin
      if (d !== 16'h0000 || e !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL idle_zero[%0d] cyc=%0d got data=%h err=%b, required 0 0",
                 k, cyc, d, e);
      end
      if (n > 0) begin
        x = (k == 0) ? qa[0] : qb[0];
        if (x.due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing[%0d] cyc=%0d got no response, required data=%h due=%0d",
                   k, cyc, x.d, x.due);
          if (k == 0) void'(qa.pop_front());
          else void'(qb.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rv_a, rd_a, re_a);
    mon(1, rv_b, rd_b, re_b);
  end

  task automatic release_and_measure();
    int ta;
    int tb;
    int bad;
    ta  = -1;
    tb  = -1;
    bad = 0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 1; i <= 1200 && (ta < 0 || tb < 0); i++) begin
      @(posedge clk);
      #1;
      if (bsy_a === rdy_a || bsy_b === rdy_b) bad++;
      if (ta < 0 && rdy_a === 1'b1) ta = i;
      if (tb < 0 && rdy_b === 1'b1) tb = i;
    end
    checks += 3;
    if (ta != 1024) begin
      errors++;
      $display("FAIL sweep_a got %0d cycles, required 1024", ta);
    end
    if (tb != 1000) begin
      errors++;
      $display("FAIL sweep_b got %0d cycles, required 1000", tb);
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_vs_ready got %0d bad cycles, required 0", bad);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    flush();
    #22;
    checks += 2;
    if (rdy_a !== 1'b0 || bsy_a !== 1'b1 || rv_a !== 1'b0 ||
        rd_a !== 16'h0 || re_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a got rdy=%b busy=%b v=%b d=%h e=%b, required 0 1 0 0 0",
               rdy_a, bsy_a, rv_a, rd_a, re_a);
    end
    if (rdy_b !== 1'b0 || bsy_b !== 1'b1 || rv_b !== 1'b0 ||
        rd_b !== 16'h0 || re_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got rdy=%b busy=%b v=%b d=%h e=%b, required 0 1 0 0 0",
               rdy_b, bsy_b, rv_b, rd_b, re_b);
    end
    release_and_measure();

    issue(1'b0, 500, 16'h0, 2'b00);
    issue(1'b1, 500, 16'h1234, 2'b11);
    issue(1'b0, 500, 16'h0, 2'b00);
    issue(1'b1, 500, 16'hABCD, 2'b01);
    issue(1'b0, 500, 16'h0, 2'b00);
    for (int i = 0; i < 10; i++)
      issue(1'b1, 500 + i, 16'(i + 1), 2'b11);
    for (int i = 0; i < 10; i++)
      issue(1'b0, 500 + i, 16'h0, 2'b00);
    issue(1'b1, 1010, 16'hFFFF, 2'b11);
    issue(1'b0, 1010, 16'h0, 2'b00);
    issue(1'b0, 999, 16'h0, 2'b00);
    issue(1'b0, 1023, 16'h0, 2'b00);
    idle();

    for (int n = 0; n < 400; n++) begin
      int a;
      if ($urandom_range(0, 7) == 0) begin
        idle();
      end else begin
        a = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023)
                                        : $urandom_range(0, 1023);
        issue(($urandom_range(0, 9) < 4), a, 16'($urandom),
              2'($urandom_range(0, 3)));
      end
    end
    idle();
    repeat (5) @(posedge clk);

    issue(1'b0, 777, 16'h0, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    flush();
    #1;
    checks++;
    if (rv_a !== 1'b0 || rv_b !== 1'b0) begin
      errors++;
      $display("FAIL rst_kill got v_a=%b v_b=%b, required 0 0", rv_a, rv_b);
    end
    repeat (3) @(posedge clk);
    release_and_measure();

    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || bsy_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep got rdy_a=%b rdy_b=%b busy_a=%b, required 0 0 1",
               rdy_a, rdy_b, bsy_a);
    end
    repeat (3) @(posedge clk);
    release_and_measure();

    issue(1'b0, 500, 16'h0, 2'b00);
    issue(1'b0, 1010, 16'h0, 2'b00);
    idle();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending, required 0/0",
               qa.size(), qb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
